apb_regfile_slave: RTL and testbench
====================================

# apb_regfile_slave

APB completer (slave) holding a small bank of 32-bit registers. It sits directly downstream of `apb_master` and consumes its `PSELx`/`PENABLE`/`PADDR`/`PWRITE`/`PWDATA` outputs. It returns `PRDATA`/`PREADY`/`PSLVERR` with a programmable number of wait states. It is the standard target for master equivalence and integration benches.

## Interface
- `NREGS`, 8: number of registers; power of 2, range 2..256.
- `WAIT_CYCLES`, 0: `PREADY`-low cycles inserted in the access phase; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte base address; aligned to 4*`NREGS`.
- `ID_VALUE`, 32'hA9B0_0001: read-only contents of register 0.

Ports:
- `i_clk` in 1: clock. All logic on rising edge.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `PSELx` in 1: select from master.
- `PENABLE` in 1: access-phase indicator.
- `PADDR` in 32: byte address.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: transfer completes this cycle.
- `PSLVERR` out 1: transfer error; valid only with `PREADY`.
- `o_wr_strobe` out 1: one-cycle pulse on each committed write.
- `o_wr_idx` out 8: register index of the committed write; zero-extended.

## Operation
- **Register map:** index = `PADDR`[2+:log2(`NREGS`)].
  - Reg 0 is read-only and returns `ID_VALUE`.
  - Regs 1..`NREGS`-1 are read/write and reset to 0.
- **Decode error:** raised if any of the following holds:
  - `PADDR`[1:0] != 0;
  - `PADDR` is outside [`BASE_ADDR`, `BASE_ADDR`+4*`NREGS`-1];
  - `PWRITE`=1 to index 0.
- **State machine:** two states, IDLE and ACCESS, plus a 4-bit wait counter `cnt`.
  - IDLE: on `PSELx`=1 and `PENABLE`=0 (setup phase), load `cnt`=`WAIT_CYCLES` and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS with `PSELx`=0: protocol abort. Go to IDLE; no write, no strobe.
  - ACCESS with `cnt`!=0: decrement `cnt`; `PREADY`=0.
  - ACCESS with `cnt`=0: `PREADY`=1, and the transfer completes when `PENABLE`=1. Then go to IDLE.
- **Outputs at completion** (derived from the current `PADDR`/`PWRITE`):
  - `PSLVERR` = decode error.
  - `PRDATA` = selected register when it is a read with no error; otherwise 0.
- **Write commit:** happens on the completing edge when `PWRITE`=1 and there is no error.
  - The register takes `PWDATA`.
  - `o_wr_strobe`=1 and `o_wr_idx`=index in the following cycle (registered).
- **Errored writes:** modify no register and produce no strobe.
- **Outside completion:** `PREADY`=0, `PSLVERR`=0, `PRDATA`=0.
- **Reset** (asynchronous, any time including mid-transfer):
  - State returns to IDLE and `cnt`=0.
  - All RW registers = 0.
  - `PREADY`=0, `PSLVERR`=0, `PRDATA`=0, `o_wr_strobe`=0, `o_wr_idx`=0.
  - An interrupted transfer is dropped and never committed.

## Timing
- Setup phase is cycle T0. The master raises `PENABLE` in T1.
- `PREADY` rises in cycle T1+`WAIT_CYCLES` and stays high for exactly one cycle per transfer.
- `WAIT_CYCLES`=0 gives zero-wait APB: `PREADY`=1 in T1 and the write lands at the end of T1.
- `o_wr_strobe` is high in the cycle after completion (T2+`WAIT_CYCLES`).
- Back-to-back transfers: a new setup phase may arrive in the cycle right after completion. IDLE accepts it with no bubble.
- A read-after-write to the same index in back-to-back transfers returns the new value.
- `PADDR`, `PWRITE` and `PWDATA` are sampled combinationally only in the completing cycle. The master holds them stable, so no internal capture register is required.
- `PRDATA`/`PREADY`/`PSLVERR` are combinational from state, `cnt` and the bus inputs. There is no input-to-output path when not in ACCESS.

## Test plan
- **Reset values:** reset with no traffic, then release.
  - All outputs are 0.
  - A read of `BASE_ADDR`+0 returns 32'hA9B0_0001 with `PSLVERR`=0.
- **Zero-wait write then read:** `WAIT_CYCLES`=0; write 32'hDEAD_BEEF to address 0x8, then read 0x8.
  - Write: `PREADY` in T1; `o_wr_strobe`=1 with `o_wr_idx`=2 in T2.
  - Read: returns 32'hDEAD_BEEF and `PSLVERR`=0.
- **Wait states:** `WAIT_CYCLES`=3; read 0x4.
  - `PREADY`=0 for T1..T3 and =1 in T4 only.
  - `PRDATA`=0 before T4.
- **Errors:** each case gives `PSLVERR`=1 at completion, no strobe and registers unchanged.
  - Write to 0x0.
  - Write to 0x6 (misaligned).
  - Read of 0x20 with `NREGS`=8: also `PRDATA`=0.
- **Abort and reset mid-transfer:**
  - `WAIT_CYCLES`=2; drop `PSELx` in T1: back to IDLE, reg 3 unchanged.
  - Assert `i_reset_n`=0 in T2 of a write to reg 3: reg 3=0 and `PREADY` never asserts.
- **Back-to-back:** 16 consecutive zero-wait writes/reads across regs 1..7 with no idle cycles.
  - Every transfer completes in 2 cycles.
  - Every readback matches the last written value.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB completer with a small bank of 32-bit registers.
// Register 0 is a read-only ID word; the others are read/write.
// A programmable number of wait states is inserted before PREADY.
module apb_regfile_slave #(
    parameter int unsigned NREGS       = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        o_wr_strobe,
    output logic [7:0]  o_wr_idx
);

    localparam int unsigned IW = $clog2(NREGS);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic            ready;
    logic            complete;
    logic            commit;

    logic [IW-1:0]   idx;
    logic [7:0]      idx_ext;
    logic            misaligned;
    logic            in_range;
    logic            dec_err;
    logic [31:0]     rd_val;

    logic [31:0]     regs [NREGS];

    // Address decode and read mux; BASE_ADDR alignment lets the range test
    // reduce to an equality on the bits above the index field.
    always_comb begin
        idx        = PADDR[2 +: IW];
        misaligned = (PADDR[1:0] != 2'b00);
        in_range   = (PADDR[31:IW+2] == BASE_ADDR[31:IW+2]);
        dec_err    = misaligned || !in_range || (PWRITE && (idx == '0));
        rd_val     = (idx == '0) ? ID_VALUE : regs[idx];
        idx_ext    = '0;
        idx_ext[IW-1:0] = idx;
    end

    // State register and wait counter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: setup phase loads the wait count, access phase
    // counts down, then presents PREADY until PENABLE completes the transfer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (PSELx && !PENABLE) begin
                    state_nxt = ST_ACCESS;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            ST_ACCESS: begin
                if (!PSELx) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    ready = 1'b1;
                    if (PENABLE) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Completion-phase bus responses; everything is held at zero otherwise.
    always_comb begin
        complete = ready && PENABLE;
        commit   = complete && PWRITE && !dec_err;
        PREADY   = ready;
        PSLVERR  = complete && dec_err;
        PRDATA   = (complete && !PWRITE && !dec_err) ? rd_val : '0;
    end

    // Register bank; index 0 is never written and reads back as ID_VALUE.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[idx] <= PWDATA;
        end
    end

    // Registered write notification, one cycle after the committing edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_strobe <= 1'b0;
            o_wr_idx    <= '0;
        end else begin
            o_wr_strobe <= commit;
            if (commit) begin
                o_wr_idx <= idx_ext;
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: three instances with 0, 2 and 3
// wait states share the bus signals but each has its own select.
module tb_apb_regfile_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;

    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [2:0]  strobe;
    logic [7:0]  wr_idx [3];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int unsigned waits;
        logic        wr_ok;
        logic [7:0]  idx;
    } exp_t;

    exp_t sbq [$];

    always #5 clk = ~clk;

    apb_regfile_slave #(.NREGS(8), .WAIT_CYCLES(0)) u_w0 (
        .i_clk(clk), .i_reset_n(rst_n), .PSELx(psel[0]), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .o_wr_strobe(strobe[0]),
        .o_wr_idx(wr_idx[0])
    );

    apb_regfile_slave #(.NREGS(8), .WAIT_CYCLES(2)) u_w2 (
        .i_clk(clk), .i_reset_n(rst_n), .PSELx(psel[1]), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .o_wr_strobe(strobe[1]),
        .o_wr_idx(wr_idx[1])
    );

    apb_regfile_slave #(.NREGS(8), .WAIT_CYCLES(3)) u_w3 (
        .i_clk(clk), .i_reset_n(rst_n), .PSELx(psel[2]), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2]), .o_wr_strobe(strobe[2]),
        .o_wr_idx(wr_idx[2])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every completion, checks idle outputs,
    // wait-state count and the strobe one cycle after each good write.
    initial begin : monitor
        int unsigned wcnt [3];
        logic [2:0]  pend;
        logic [7:0]  pend_idx [3];
        exp_t        e;
        pend = '0;
        for (int d = 0; d < 3; d++) begin
            wcnt[d] = 0;
            pend_idx[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    chk("reset_pready", 32'(pready[d]), 32'd0);
                    chk("reset_strobe", 32'(strobe[d]), 32'd0);
                    wcnt[d] = 0;
                    pend[d] = 1'b0;
                end else begin
                    chk("wr_strobe", 32'(strobe[d]), 32'(pend[d]));
                    if (pend[d]) chk("wr_idx", 32'(wr_idx[d]), 32'(pend_idx[d]));
                    pend[d] = 1'b0;
                    if (psel[d] && penable && pready[d]) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_completion", 32'd1, 32'd0);
                        end else begin
                            e = sbq.pop_front();
                            chk("dut_id", 32'(d), 32'(e.d));
                            chk("prdata", prdata[d], e.rdata);
                            chk("pslverr", 32'(pslverr[d]), 32'(e.err));
                            chk("wait_states", 32'(wcnt[d]), 32'(e.waits));
                            pend[d]     = e.wr_ok;
                            pend_idx[d] = e.idx;
                        end
                        wcnt[d] = 0;
                    end else begin
                        chk("idle_prdata", prdata[d], 32'd0);
                        chk("idle_pslverr", 32'(pslverr[d]), 32'd0);
                        if (psel[d] && penable) wcnt[d]++;
                        else wcnt[d] = 0;
                    end
                end
            end
        end
    end

    // One APB transfer on instance d; leaves the bus ready for a back-to-back
    // setup phase or for idle_bus().
    task automatic xfer(input int d, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [31:0] erd,
                        input logic eerr, input int unsigned ew);
        exp_t        e;
        int unsigned cyc;
        logic        done;
        e.d = d; e.rdata = erd; e.err = eerr; e.waits = ew;
        e.wr_ok = w && !eerr; e.idx = 8'(a[4:2]);
        sbq.push_back(e);
        psel = '0; psel[d] = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (pready[d]) done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("xfer_cycles", 32'(cyc), 32'(2 + ew));
        penable = 1'b0;
    endtask

    task automatic idle_bus(input int n);
        psel = '0; penable = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : stim
        logic [31:0] v;
        logic [31:0] a;
        rst_n = 1'b0; psel = '0; penable = 1'b0;
        paddr = '0; pwrite = 1'b0; pwdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_prdata", prdata[d], 32'd0);
            chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
            chk("rst_wr_idx", 32'(wr_idx[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 32'h0, 1'b0, '0, 32'hA9B0_0001, 1'b0, 0);
        idle_bus(1);

        // Zero-wait write then read
        xfer(0, 32'h8, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        idle_bus(1);
        xfer(0, 32'h8, 1'b0, '0, 32'hDEAD_BEEF, 1'b0, 0);
        idle_bus(2);

        // Three wait states
        xfer(2, 32'h4, 1'b0, '0, 32'h0, 1'b0, 3);
        idle_bus(1);

        // Decode errors, then confirm nothing changed
        xfer(0, 32'h0, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 0);
        xfer(0, 32'h6, 1'b1, 32'h5555_5555, 32'h0, 1'b1, 0);
        xfer(0, 32'h20, 1'b0, '0, 32'h0, 1'b1, 0);
        xfer(0, 32'h4, 1'b0, '0, 32'h0, 1'b0, 0);
        xfer(0, 32'h0, 1'b0, '0, 32'hA9B0_0001, 1'b0, 0);
        idle_bus(2);

        // Abort with PSELx dropped in T1
        xfer(1, 32'hC, 1'b1, 32'h0000_0033, 32'h0, 1'b0, 2);
        idle_bus(1);
        psel = 3'b010; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h0000_0BAD;
        @(posedge clk); #1;
        psel = '0; penable = 1'b1;
        idle_bus(4);
        xfer(1, 32'hC, 1'b0, '0, 32'h0000_0033, 1'b0, 2);
        idle_bus(1);

        // Back-to-back zero-wait write/read pairs over regs 1..7
        for (int i = 0; i < 8; i++) begin
            a = 32'((i % 7) + 1) << 2;
            v = 32'hA000_0000 + 32'(i) * 32'h0000_1111;
            xfer(0, a, 1'b1, v, 32'h0, 1'b0, 0);
            xfer(0, a, 1'b0, '0, v, 1'b0, 0);
        end
        xfer(0, 32'h4, 1'b0, '0, 32'hA000_7777, 1'b0, 0);
        idle_bus(2);

        // Reset in T2 of a write to reg 3 on the 3-wait instance
        psel = 3'b100; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h0000_0077;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_rst_pready", 32'(pready[2]), 32'd0);
        end
        psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_bus(1);
        xfer(2, 32'hC, 1'b0, '0, 32'h0, 1'b0, 3);
        idle_bus(1);
        xfer(0, 32'h8, 1'b0, '0, 32'h0, 1'b0, 0);
        idle_bus(3);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
